ram_dp_param: RTL and testbench

- Parametrised dual-port distributed RAM: one synchronous write/read port (A, D, WE → SPO) and one independent read port (DPRA → DPO).
- Generalises the 16x1 dual-port primitive to WIDTH bits × 2^ADDR_W words.
- Adds a reset-driven clear sequencer, an optional registered-output mode with write-first bypass, and a write/read collision flag.
- Used as a register file / scratchpad inside processor-style datapaths.

---
 rtl/ram_dp_param.sv | 136 +++++++++++++
 tb/tb_ram_dp_param.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_dp_param.sv
// ============================================================================
// Module      : ram_dp_param
// Description : Dual-port distributed RAM (one write/read port, one read port)
//               with reset-driven clear sequencer, optional registered
//               write-first outputs and a write/read collision flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_dp_param #(
    parameter int               WIDTH     = 8,
    parameter int               ADDR_W    = 4,
    parameter logic [WIDTH-1:0] INIT_WORD = '0,
    parameter bit               OUT_REG   = 1'b0
) (
    input  logic              WCLK,
    input  logic              RST,
    input  logic              WE,
    input  logic [ADDR_W-1:0] A,
    input  logic [WIDTH-1:0]  D,
    input  logic [ADDR_W-1:0] DPRA,
    output logic [WIDTH-1:0]  SPO,
    output logic [WIDTH-1:0]  DPO,
    output logic              BUSY,
    output logic              COLL
);

    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [0:0]        ST_CLEAR = 1'b0;
    localparam logic [0:0]        ST_READY = 1'b1;
    localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              coll_q, coll_d;

    logic              ready;
    logic              a_match;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WIDTH-1:0]  mem_wdata;
    logic [WIDTH-1:0]  mem [DEPTH];

    // State register
    always_ff @(posedge WCLK) begin
        if (RST) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            coll_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            coll_q  <= coll_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: state_d = ST_READY;
            default:  state_d = ST_CLEAR;
        endcase
    end

    // Output / memory-write logic: the clear sequencer owns the write port
    // until READY, so user writes are dropped while clearing.
    always_comb begin
        ready     = (state_q == ST_READY);
        a_match   = (DPRA == A);
        coll_d    = ready && WE && a_match;
        mem_we    = 1'b0;
        mem_waddr = A;
        mem_wdata = D;
        if (!RST) begin
            if (ready) begin
                mem_we = WE;
            end else begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = INIT_WORD;
            end
        end
    end

    always_ff @(posedge WCLK) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    generate
        if (OUT_REG) begin : g_out_reg
            logic [WIDTH-1:0] spo_q, spo_d;
            logic [WIDTH-1:0] dpo_q, dpo_d;

            always_comb begin
                spo_d = '0;
                dpo_d = '0;
                if (ready) begin
                    spo_d = WE ? D : mem[A];
                    dpo_d = (WE && a_match) ? D : mem[DPRA];
                end
            end

            always_ff @(posedge WCLK) begin
                if (RST) begin
                    spo_q <= '0;
                    dpo_q <= '0;
                end else begin
                    spo_q <= spo_d;
                    dpo_q <= dpo_d;
                end
            end

            assign SPO = spo_q;
            assign DPO = dpo_q;
        end else begin : g_out_comb
            assign SPO = mem[A];
            assign DPO = mem[DPRA];
        end
    endgenerate

    assign BUSY = RST || (state_q == ST_CLEAR);
    assign COLL = coll_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_dp_param.sv
// ============================================================================
// Module      : tb_ram_dp_param
// Description : Directed self-checking bench for ram_dp_param (combinational,
//               registered and 1x2 corner configurations).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_dp_param;

    logic       clk = 1'b0;
    logic       rst, we;
    logic [3:0] a, dpra;
    logic [7:0] d;
    logic [7:0] c_spo, c_dpo, r_spo, r_dpo;
    logic       c_busy, c_coll, r_busy, r_coll;

    logic t_rst, t_we, t_a, t_d, t_dpra;
    logic t_spo, t_dpo, t_busy, t_coll;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ram_dp_param #(.WIDTH(8), .ADDR_W(4), .INIT_WORD(8'hA5), .OUT_REG(1'b0)) u_comb (
        .WCLK(clk), .RST(rst), .WE(we), .A(a), .D(d), .DPRA(dpra),
        .SPO(c_spo), .DPO(c_dpo), .BUSY(c_busy), .COLL(c_coll)
    );

    ram_dp_param #(.WIDTH(8), .ADDR_W(4), .INIT_WORD(8'hA5), .OUT_REG(1'b1)) u_reg (
        .WCLK(clk), .RST(rst), .WE(we), .A(a), .D(d), .DPRA(dpra),
        .SPO(r_spo), .DPO(r_dpo), .BUSY(r_busy), .COLL(r_coll)
    );

    ram_dp_param #(.WIDTH(1), .ADDR_W(1), .INIT_WORD(1'b0), .OUT_REG(1'b0)) u_tiny (
        .WCLK(clk), .RST(t_rst), .WE(t_we), .A(t_a), .D(t_d), .DPRA(t_dpra),
        .SPO(t_spo), .DPO(t_dpo), .BUSY(t_busy), .COLL(t_coll)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; we = 1'b1; a = 4'd3; dpra = 4'd3; d = 8'hFF;
        repeat (3) tick();
        total++; if (c_busy !== 1'b1) begin bad++; $display("FAIL reset_busy_comb got=%b exp=1", c_busy); end
        total++; if (c_coll !== 1'b0) begin bad++; $display("FAIL reset_coll_comb got=%b exp=0", c_coll); end
        total++; if (r_busy !== 1'b1) begin bad++; $display("FAIL reset_busy_reg got=%b exp=1", r_busy); end
        total++; if (r_coll !== 1'b0) begin bad++; $display("FAIL reset_coll_reg got=%b exp=0", r_coll); end
        total++; if (r_spo !== 8'h00) begin bad++; $display("FAIL reset_spo_reg got=%h exp=00", r_spo); end
        total++; if (r_dpo !== 8'h00) begin bad++; $display("FAIL reset_dpo_reg got=%h exp=00", r_dpo); end
    endtask

    task automatic sweep_all_a5();
        we = 1'b0;
        for (int i = 0; i < 16; i++) begin
            a = 4'(i); dpra = 4'(15 - i);
            tick();
            total++; if (c_spo !== 8'hA5) begin bad++; $display("FAIL sweep_spo_comb a=%0d got=%h exp=a5", i, c_spo); end
            total++; if (c_dpo !== 8'hA5) begin bad++; $display("FAIL sweep_dpo_comb dpra=%0d got=%h exp=a5", 15 - i, c_dpo); end
            total++; if (r_spo !== 8'hA5) begin bad++; $display("FAIL sweep_spo_reg a=%0d got=%h exp=a5", i, r_spo); end
            total++; if (r_dpo !== 8'hA5) begin bad++; $display("FAIL sweep_dpo_reg dpra=%0d got=%h exp=a5", 15 - i, r_dpo); end
        end
    endtask

    task automatic test_clear();
        int edges;
        we = 1'b0; rst = 1'b0; edges = 0;
        while (c_busy && edges < 40) begin
            tick();
            edges++;
        end
        total++; if (edges !== 16) begin bad++; $display("FAIL clear_busy_edges got=%0d exp=16", edges); end
        total++; if (r_busy !== 1'b0) begin bad++; $display("FAIL clear_busy_reg got=%b exp=0", r_busy); end
        sweep_all_a5();
    endtask

    task automatic test_write_readback();
        we = 1'b1; a = 4'd5; d = 8'h3C; dpra = 4'd0;
        tick();
        we = 1'b0;
        #1;
        total++; if (c_spo !== 8'h3C) begin bad++; $display("FAIL wr_spo_a5 got=%h exp=3c", c_spo); end
        total++; if (r_spo !== 8'h3C) begin bad++; $display("FAIL wr_spo_reg_first got=%h exp=3c", r_spo); end
        we = 1'b1; a = 4'd15; d = 8'hC3;
        tick();
        we = 1'b0; dpra = 4'd15;
        #1;
        total++; if (c_dpo !== 8'hC3) begin bad++; $display("FAIL wr_dpo_a15 got=%h exp=c3", c_dpo); end
        dpra = 4'd4;
        #1;
        total++; if (c_dpo !== 8'hA5) begin bad++; $display("FAIL wr_dpo_a4 got=%h exp=a5", c_dpo); end
        a = 4'd5;
        tick();
        total++; if (r_spo !== 8'h3C) begin bad++; $display("FAIL wr_spo_reg_a5 got=%h exp=3c", r_spo); end
        total++; if (r_dpo !== 8'hA5) begin bad++; $display("FAIL wr_dpo_reg_a4 got=%h exp=a5", r_dpo); end
    endtask

    task automatic test_bypass();
        we = 1'b1; a = 4'd7; dpra = 4'd7; d = 8'h5A;
        tick();
        we = 1'b0;
        total++; if (r_spo !== 8'h5A) begin bad++; $display("FAIL byp_spo got=%h exp=5a", r_spo); end
        total++; if (r_dpo !== 8'h5A) begin bad++; $display("FAIL byp_dpo got=%h exp=5a", r_dpo); end
        total++; if (r_coll !== 1'b1) begin bad++; $display("FAIL byp_coll_reg got=%b exp=1", r_coll); end
        total++; if (c_coll !== 1'b1) begin bad++; $display("FAIL byp_coll_comb got=%b exp=1", c_coll); end
        tick();
        total++; if (r_coll !== 1'b0) begin bad++; $display("FAIL byp_coll_clr got=%b exp=0", r_coll); end
        total++; if (r_dpo !== 8'h5A) begin bad++; $display("FAIL byp_dpo_hold got=%h exp=5a", r_dpo); end
        // write to a different address than the one port B reads
        we = 1'b1; a = 4'd8; d = 8'h77;
        tick();
        we = 1'b0;
        total++; if (r_spo !== 8'h77) begin bad++; $display("FAIL byp_nc_spo got=%h exp=77", r_spo); end
        total++; if (r_dpo !== 8'h5A) begin bad++; $display("FAIL byp_nc_dpo got=%h exp=5a", r_dpo); end
        total++; if (r_coll !== 1'b0) begin bad++; $display("FAIL byp_nc_coll got=%b exp=0", r_coll); end
    endtask

    task automatic test_reset_mid_clear();
        int edges;
        we = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (9) tick();
        total++; if (c_busy !== 1'b1) begin bad++; $display("FAIL mid_busy_step9 got=%b exp=1", c_busy); end
        rst = 1'b1;
        tick();
        total++; if (c_busy !== 1'b1) begin bad++; $display("FAIL mid_busy_rst got=%b exp=1", c_busy); end
        rst = 1'b0; edges = 0;
        while (c_busy && edges < 40) begin
            tick();
            edges++;
        end
        total++; if (edges !== 16) begin bad++; $display("FAIL mid_busy_edges got=%0d exp=16", edges); end
        sweep_all_a5();
    endtask

    task automatic test_write_during_clear();
        int edges;
        bit coll_seen;
        rst = 1'b1; we = 1'b0;
        tick();
        we = 1'b1; a = 4'd2; d = 8'h11; dpra = 4'd2;
        rst = 1'b0; edges = 0; coll_seen = 1'b0;
        while (c_busy && edges < 40) begin
            tick();
            edges++;
            if (c_coll || r_coll) coll_seen = 1'b1;
        end
        we = 1'b0;
        total++; if (edges !== 16) begin bad++; $display("FAIL wdc_busy_edges got=%0d exp=16", edges); end
        total++; if (coll_seen !== 1'b0) begin bad++; $display("FAIL wdc_coll_seen got=%b exp=0", coll_seen); end
        #1;
        total++; if (c_spo !== 8'hA5) begin bad++; $display("FAIL wdc_mem2_comb got=%h exp=a5", c_spo); end
        tick();
        total++; if (r_spo !== 8'hA5) begin bad++; $display("FAIL wdc_mem2_reg got=%h exp=a5", r_spo); end
    endtask

    task automatic test_tiny();
        int edges;
        t_rst = 1'b1; t_we = 1'b0; t_a = 1'b0; t_d = 1'b0; t_dpra = 1'b0;
        repeat (2) tick();
        total++; if (t_busy !== 1'b1) begin bad++; $display("FAIL tiny_reset_busy got=%b exp=1", t_busy); end
        t_rst = 1'b0; edges = 0;
        while (t_busy && edges < 40) begin
            tick();
            edges++;
        end
        total++; if (edges !== 2) begin bad++; $display("FAIL tiny_busy_edges got=%0d exp=2", edges); end
        t_we = 1'b1; t_a = 1'b1; t_d = 1'b1;
        tick();
        t_we = 1'b0; t_dpra = 1'b1;
        #1;
        total++; if (t_dpo !== 1'b1) begin bad++; $display("FAIL tiny_dpo1 got=%b exp=1", t_dpo); end
        total++; if (t_spo !== 1'b1) begin bad++; $display("FAIL tiny_spo1 got=%b exp=1", t_spo); end
        t_dpra = 1'b0;
        #1;
        total++; if (t_dpo !== 1'b0) begin bad++; $display("FAIL tiny_dpo0 got=%b exp=0", t_dpo); end
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; a = '0; dpra = '0; d = '0;
        t_rst = 1'b1; t_we = 1'b0; t_a = 1'b0; t_d = 1'b0; t_dpra = 1'b0;
        test_reset();
        test_clear();
        test_write_readback();
        test_bypass();
        test_reset_mid_clear();
        test_write_during_clear();
        test_tiny();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
